// File: rtl/rot_pkg.sv
// -----------------------------------------------------------------------------
// rot_pkg
//   Shared definitions for the hash-datapath rotators (rotl_pipe and the
//   existing right-rotator).
//
//   Contents:
//     ROT_DATA_WIDTH   default operand width (256)
//     ROT_SHIFT_WIDTH  shift bits actually used = log2(width) (8)
//     rot_word_t       operand word at the default width
//     rotl_const       rotate left by the fixed amount 2^k
//     rotr_const       rotate right by the fixed amount 2^k
//     stage_amount     rotate distance handled by pipeline stage k
//
//   The functions work on the default width only. The pipelined rotators
//   slice inline so they stay correct when they are built at other widths.
// -----------------------------------------------------------------------------
package rot_pkg;

    localparam int ROT_DATA_WIDTH  = 256;
    localparam int ROT_SHIFT_WIDTH = $clog2(ROT_DATA_WIDTH);

    typedef logic [ROT_DATA_WIDTH-1:0] rot_word_t;

    // Rotate distance of stage k: stage k rotates by 2^k or by nothing.
    function automatic int unsigned stage_amount(input int unsigned k);
        return 32'd1 << k;
    endfunction

    // Rotate x left by 2^k. 2^k is reduced modulo the width, so a zero
    // distance returns x and the shift by the full width is never formed.
    function automatic rot_word_t rotl_const(input rot_word_t x, input int unsigned k);
        int unsigned n;
        n = stage_amount(k) % unsigned'(ROT_DATA_WIDTH);
        if (n == 32'd0) begin
            return x;
        end else begin
            return (x << n) | (x >> (unsigned'(ROT_DATA_WIDTH) - n));
        end
    endfunction

    // Rotate x right by 2^k. This is the inverse of rotl_const.
    function automatic rot_word_t rotr_const(input rot_word_t x, input int unsigned k);
        int unsigned n;
        n = stage_amount(k) % unsigned'(ROT_DATA_WIDTH);
        if (n == 32'd0) begin
            return x;
        end else begin
            return (x >> n) | (x << (unsigned'(ROT_DATA_WIDTH) - n));
        end
    endfunction

endpackage

// File: rtl/rotl_pipe_if.sv
// -----------------------------------------------------------------------------
// rotl_pipe_if
//   Operand and result stream bundle for rotl_pipe.
//
//   Parameter:
//     DATA_WIDTH  operand width. It must match the DATA_WIDTH of the rotl_pipe
//                 that is attached.
//
//   Signals:
//     in_valid   producer -> unit      a_in/shift_in carry an operand
//     in_ready   unit -> producer      unit accepts an operand this cycle
//     a_in       producer -> unit      word to rotate
//     shift_in   producer -> unit      rotate amount (only the low log2 bits count)
//     out_valid  unit -> consumer      a_out holds a result
//     out_ready  consumer -> unit      consumer takes the result this cycle
//     a_out      unit -> consumer      rotated word
//
//   Modports:
//     master  the environment side (producer and consumer)
//     slave   the rotator side
// -----------------------------------------------------------------------------
interface rotl_pipe_if
    import rot_pkg::*;
#(
    parameter int DATA_WIDTH = ROT_DATA_WIDTH
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] shift_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] a_out;

    modport master (
        output in_valid,
        output a_in,
        output shift_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  a_out
    );

    modport slave (
        input  in_valid,
        input  a_in,
        input  shift_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output a_out
    );

endinterface

// File: rtl/rotl_stage.sv
// -----------------------------------------------------------------------------
// rotl_stage
//   One stage of the rotate-left pipeline. On advance the stage registers its
//   input word, rotated left by 2^STAGE when in_shift[STAGE] is set and
//   unchanged otherwise. The valid bit and the shift amount travel with the
//   word. When advance is low every register holds its value.
//
//   Parameters:
//     DATA_WIDTH   word width (power of two, >= 2)
//     SHIFT_WIDTH  width of the shift amount carried along
//     STAGE        index of this stage. The stage rotates by 2^STAGE.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset; clears valid, data and shift
//     advance    the whole pipe moves this cycle
//     in_valid   incoming slot holds an operand
//     in_data    incoming word
//     in_shift   incoming shift amount
//     out_valid  registered valid bit
//     out_data   registered (conditionally rotated) word
//     out_shift  registered shift amount, passed to the next stage
// -----------------------------------------------------------------------------
module rotl_stage
    import rot_pkg::*;
#(
    parameter int DATA_WIDTH  = ROT_DATA_WIDTH,
    parameter int SHIFT_WIDTH = ROT_SHIFT_WIDTH,
    parameter int STAGE       = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   advance,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [SHIFT_WIDTH-1:0] in_shift,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [SHIFT_WIDTH-1:0] out_shift
);

    // The highest stage rotates by DATA_WIDTH/2, so both slices below stay in range.
    localparam int AMT = 1 << STAGE;

    logic [DATA_WIDTH-1:0]  rot_s;
    logic                   valid_d;
    logic                   valid_q;
    logic [DATA_WIDTH-1:0]  data_d;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [SHIFT_WIDTH-1:0] shift_d;
    logic [SHIFT_WIDTH-1:0] shift_q;

    // Fixed rotate by 2^STAGE. This is pure wiring, selected by one shift bit.
    always_comb begin
        rot_s = in_data;
        if (in_shift[STAGE]) begin
            rot_s = {in_data[DATA_WIDTH-1-AMT:0], in_data[DATA_WIDTH-1:DATA_WIDTH-AMT]};
        end else begin
            rot_s = in_data;
        end
    end

    // Next state: load on advance, otherwise hold. A bubble loads valid=0.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shift_d = shift_q;
        if (advance) begin
            valid_d = in_valid;
            data_d  = rot_s;
            shift_d = in_shift;
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
            shift_d = shift_q;
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {DATA_WIDTH{1'b0}};
            shift_q <= {SHIFT_WIDTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shift_q <= shift_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_shift = shift_q;

endmodule

// File: rtl/rotl_pipe.sv
// -----------------------------------------------------------------------------
// rotl_pipe
//   Pipelined rotate-left unit. It is the inverse of the right-rotator in the
//   hash datapath. It accepts one operand per cycle and returns a_in rotated
//   left by (shift_in mod DATA_WIDTH) SHIFT_WIDTH cycles after acceptance.
//   Stage k rotates by 2^k when bit k of the shift is set.
//
//   Handshake:
//     advance  = enable & (~out_valid | out_ready)
//     in_ready = advance, forced low while rst_n is low
//   All stages move together or all hold, so the pipe never collapses
//   bubbles. Results leave in acceptance order. When the pipe is full and
//   out_ready and in_valid are both high in the same cycle, the result leaves
//   and the new operand enters on the same edge.
//
//   Parameters:
//     DATA_WIDTH   operand width (power of two, >= 2). It must equal the width
//                  of the attached interface.
//     SHIFT_WIDTH  log2(DATA_WIDTH). This is both the number of shift bits
//                  used and the pipeline depth.
//
//   Ports:
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset. It flushes all in-flight operands.
//     enable  global advance enable. When low, the whole pipe holds.
//     bus     rotl_pipe_if.slave: in_valid/in_ready/a_in/shift_in and
//             out_valid/out_ready/a_out
//
//   a_out and out_valid come straight from the last stage's registers.
// -----------------------------------------------------------------------------
module rotl_pipe
    import rot_pkg::*;
#(
    parameter int DATA_WIDTH  = ROT_DATA_WIDTH,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    rotl_pipe_if.slave  bus
);

    logic advance_s;
    logic in_ready_s;
    logic accept_s;

    // Outputs of every stage. Index SHIFT_WIDTH-1 is the last stage.
    logic                   valid_s [SHIFT_WIDTH];
    logic [DATA_WIDTH-1:0]  data_s  [SHIFT_WIDTH];
    logic [SHIFT_WIDTH-1:0] shift_s [SHIFT_WIDTH];

    // The shift bits above SHIFT_WIDTH are ignored. This is how shifts of
    // DATA_WIDTH or more wrap modulo DATA_WIDTH. After the last stage the
    // shift has no further use.
    logic unused_shift_s;

    // Handshake glue. A full pipe can still advance when the consumer takes the head.
    always_comb begin
        advance_s  = enable & (~bus.out_valid | bus.out_ready);
        in_ready_s = advance_s & rst_n;
        accept_s   = bus.in_valid & in_ready_s;
    end

    assign bus.in_ready = in_ready_s;

    for (genvar g = 0; g < SHIFT_WIDTH; g++) begin : g_stage
        logic                   v_in_s;
        logic [DATA_WIDTH-1:0]  d_in_s;
        logic [SHIFT_WIDTH-1:0] s_in_s;

        if (g == 0) begin : g_first
            // Stage 0 takes the operand. When no operand is accepted it takes a bubble.
            assign v_in_s = accept_s;
            assign d_in_s = bus.a_in;
            assign s_in_s = bus.shift_in[SHIFT_WIDTH-1:0];
        end else begin : g_next
            assign v_in_s = valid_s[g-1];
            assign d_in_s = data_s[g-1];
            assign s_in_s = shift_s[g-1];
        end

        rotl_stage #(
            .DATA_WIDTH  (DATA_WIDTH),
            .SHIFT_WIDTH (SHIFT_WIDTH),
            .STAGE       (g)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (advance_s),
            .in_valid  (v_in_s),
            .in_data   (d_in_s),
            .in_shift  (s_in_s),
            .out_valid (valid_s[g]),
            .out_data  (data_s[g]),
            .out_shift (shift_s[g])
        );
    end

    assign bus.out_valid = valid_s[SHIFT_WIDTH-1];
    assign bus.a_out     = data_s[SHIFT_WIDTH-1];

    assign unused_shift_s = ^{bus.shift_in[DATA_WIDTH-1:SHIFT_WIDTH], shift_s[SHIFT_WIDTH-1]};

endmodule

// File: tb/tb_rotl_pipe.sv
// -----------------------------------------------------------------------------
// tb_rotl_pipe
//   Scoreboard bench for rotl_pipe at the default 256-bit width. Stimulus
//   tasks push the expected results into a queue. A monitor on the falling
//   edge pops an entry and compares it each time the DUT hands over a result.
// -----------------------------------------------------------------------------
module tb_rotl_pipe;

    localparam int W  = 256;
    localparam int SW = 8;

    typedef struct {
        logic [W-1:0] val;      // expected a_out, or the original x in inverse mode
        logic [W-1:0] sh;       // shift used (inverse mode)
        bit           inverse;  // compare rotr(a_out, sh) against val
        bit           chk_lat;  // check the cycle the result first appears
        int           exp_cyc;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b0;

    rotl_pipe_if #(.DATA_WIDTH(W)) bus ();

    rotl_pipe #(.DATA_WIDTH(W), .SHIFT_WIDTH(SW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];

    bit           hold_pending = 1'b0;
    logic [W-1:0] hold_val;
    int           first_cyc = 0;
    logic [W-1:0] rx;
    logic [W-1:0] rs;

    function automatic logic [W-1:0] rotr_ref(input logic [W-1:0] v, input int n);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[(i + n) % W];
        return r;
    endfunction

    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one operand, wait (bounded) for acceptance and optionally record the expectation.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] s, input logic [W-1:0] val,
                        input bit inverse, input bit track, input bit chk_lat, input int lat);
        int waited = 0;
        bit ok = 1'b0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.shift_in = s;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no in_ready expected acceptance within 200 cycles");
        end else if (track) begin
            e.val = val; e.sh = s; e.inverse = inverse; e.chk_lat = chk_lat; e.exp_cyc = cyc + lat;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_int("drain_queue_empty", sbq.size(), 0);
    endtask

    // Monitor: checks the stability of a held result and scores every result the consumer takes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    check_int("stall_out_valid_stable", int'(bus.out_valid), 1);
                    check_vec("stall_a_out_stable", bus.a_out, hold_val);
                end
                if (bus.out_valid === 1'b1 && !hold_pending) first_cyc = cyc;
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && enable === 1'b1) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got a_out %h expected no result", bus.a_out);
                    end else begin
                        e = sbq.pop_front();
                        if (e.inverse) check_vec("rotr_roundtrip", rotr_ref(bus.a_out, int'(e.sh[SW-1:0])), e.val);
                        else           check_vec("result", bus.a_out, e.val);
                        if (e.chk_lat) check_int("latency_cycle", first_cyc, e.exp_cyc);
                    end
                    hold_pending = 1'b0;
                end else if (bus.out_valid === 1'b1) begin
                    hold_pending = 1'b1;
                    hold_val     = bus.a_out;
                end else begin
                    hold_pending = 1'b0;
                end
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a_in      = {W{1'b0}};
        bus.shift_in  = {W{1'b0}};
        bus.out_ready = 1'b1;
        enable        = 1'b1;
        rst_n         = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("reset_out_valid", int'(bus.out_valid), 0);
        check_vec("reset_a_out", bus.a_out, {W{1'b0}});
        check_int("reset_in_ready", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic rotate by one, with a latency check of 8 cycles
        send(256'h1, 256'h1, 256'h2, 1'b0, 1'b1, 1'b1, 8);
        drain(30);

        // 2/3: wrap, zero shift, ignored upper shift bits, large shifts
        send({4'h8, 252'h0}, 256'd1, 256'h1, 1'b0, 1'b1, 1'b1, 8);
        send({4'h8, 248'h0, 4'h1}, 256'd255, {4'hC, 252'h0}, 1'b0, 1'b1, 1'b1, 8);
        send(256'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 256'd0,
             256'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b0, 1'b1, 1'b1, 8);
        send(256'hF, 256'h103, 256'h78, 1'b0, 1'b1, 1'b1, 8);
        send(256'hF, 256'h100, 256'hF, 1'b0, 1'b1, 1'b1, 8);
        send(256'h1, 256'd128, {127'h0, 1'b1, 128'h0}, 1'b0, 1'b1, 1'b1, 8);
        send(256'h0123456789ABCDEF, 256'd4, 256'h123456789ABCDEF0, 1'b0, 1'b1, 1'b1, 8);
        drain(30);

        // 4: ten back-to-back operands, consumer stalls in stream cycles 9..13
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(256'd3, 256'(i * 20), 256'd3 << (i * 20), 1'b0, 1'b1, 1'b0, 0);
            end
            begin
                for (int k = 0; k < 14; k++) begin
                    bus.out_ready = !(k >= 9 && k <= 13);
                    @(negedge clk);
                    if (k >= 9) check_int("stall_in_ready_low", int'(bus.in_ready), 0);
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain(40);

        // 5: enable low for 3 cycles after three operands, so each result is 3 cycles late
        send(256'h5, 256'd252, {4'h5, 252'h0}, 1'b0, 1'b1, 1'b1, 11);
        send(256'h5, 256'd253, {4'hA, 252'h0}, 1'b0, 1'b1, 1'b1, 11);
        send(256'h5, 256'd254, {4'h4, 251'h0, 1'b1}, 1'b0, 1'b1, 1'b1, 11);
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_int("disabled_in_ready_low", int'(bus.in_ready), 0);
            @(posedge clk); #1;
        end
        enable = 1'b1;
        drain(40);

        // 6a: reset with four operands in flight (head held at the output)
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(256'hA5A5_0000_5A5A + 256'(i), 256'(i + 1), {W{1'b0}}, 1'b0, 1'b0, 1'b0, 0);
        begin
            int n = 0;
            while (bus.out_valid !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check_int("flush_head_reached_output", int'(bus.out_valid), 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_int("flush_out_valid", int'(bus.out_valid), 0);
        check_vec("flush_a_out", bus.a_out, {W{1'b0}});
        check_int("flush_in_ready", int'(bus.in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // 6b: 1000 random pairs. Rotating each result back right must give x.
        for (int i = 0; i < 1000; i++) begin
            for (int j = 0; j < W / 32; j++) begin
                rx[j*32 +: 32] = $urandom();
                rs[j*32 +: 32] = $urandom();
            end
            send(rx, rs, rx, 1'b1, 1'b1, 1'b0, 0);
        end
        drain(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
